// File: rtl/ps2_arrow_decoder.sv
// ps2_arrow_decoder
// Receive-only PS/2 keyboard interface that turns the extended left/right
// arrow make and break codes into held-key levels for the basket controller.
// Optional build macro PS2_WASD_EN: when defined, the plain A (0x1C) and
// D (0x23) keys also drive left_held / right_held alongside the arrows.

module ps2_arrow_decoder #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       left_held,
    output logic       right_held,
    output logic [7:0] scan_byte,
    output logic       byte_valid,
    output logic       frame_error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   ps2_clk_s;
    logic                   dat_bit;
    logic                   fall;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_reg;
    logic                   parity_bit;
    logic [CNT_W-1:0]       idle_cnt;
    logic                   pending;
    logic                   ext_seen;
    logic                   brk_seen;
    logic                   left_arrow;
    logic                   right_arrow;
`ifdef PS2_WASD_EN
    logic                   left_letter;
    logic                   right_letter;
`endif

    assign ps2_clk_s = clk_sync[SYNC_STAGES-1];
    assign dat_bit   = dat_sync[SYNC_STAGES-1];
    assign fall      = clk_prev & ~ps2_clk_s;

`ifdef PS2_WASD_EN
    assign left_held  = left_arrow | left_letter;
    assign right_held = right_arrow | right_letter;
`else
    assign left_held  = left_arrow;
    assign right_held = right_arrow;
`endif

    // Bring the keyboard pins into the Clock domain; preset high so reset looks like an idle bus
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DAT};
            clk_prev <= ps2_clk_s;
        end
    end

    // Frame receiver, inactivity timeout and scan-code decode; a completed byte is decoded one cycle after its stop bit
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            bit_cnt      <= 3'd0;
            shift_reg    <= 8'h00;
            parity_bit   <= 1'b0;
            idle_cnt     <= '0;
            pending      <= 1'b0;
            byte_valid   <= 1'b0;
            frame_error  <= 1'b0;
            scan_byte    <= 8'h00;
            ext_seen     <= 1'b0;
            brk_seen     <= 1'b0;
            left_arrow   <= 1'b0;
            right_arrow  <= 1'b0;
`ifdef PS2_WASD_EN
            left_letter  <= 1'b0;
            right_letter <= 1'b0;
`endif
        end else begin
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
            pending     <= 1'b0;

            if (pending) begin
                byte_valid <= 1'b1;
                scan_byte  <= shift_reg;
                if (shift_reg == 8'hE0) begin
                    ext_seen <= 1'b1;
                end else if (shift_reg == 8'hF0) begin
                    brk_seen <= 1'b1;
                end else begin
                    if (ext_seen && shift_reg == 8'h6B) begin
                        left_arrow <= !brk_seen;
                    end
                    if (ext_seen && shift_reg == 8'h74) begin
                        right_arrow <= !brk_seen;
                    end
`ifdef PS2_WASD_EN
                    if (!ext_seen && shift_reg == 8'h1C) begin
                        left_letter <= !brk_seen;
                    end
                    if (!ext_seen && shift_reg == 8'h23) begin
                        right_letter <= !brk_seen;
                    end
`endif
                    ext_seen <= 1'b0;
                    brk_seen <= 1'b0;
                end
            end

            if (fall) begin
                idle_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!dat_bit) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_reg <= {dat_bit, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_bit <= dat_bit;
                        state      <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if ((^{shift_reg, parity_bit}) && dat_bit) begin
                            pending <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                            ext_seen    <= 1'b0;
                            brk_seen    <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (idle_cnt == CNT_LAST) begin
                    state       <= IDLE;
                    idle_cnt    <= '0;
                    frame_error <= 1'b1;
                    ext_seen    <= 1'b0;
                    brk_seen    <= 1'b0;
                end else begin
                    idle_cnt <= idle_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/ps2_arrow_decoder.md
Name: ps2_arrow_decoder

Overview:
- Receives PS/2 keyboard frames and decodes the left and right arrow make/break codes into held-key levels.
- Outputs drive the basket controller's left/right key inputs directly.
- Sits between the PS/2 pins and basket movement logic; receive-only, no host-to-device transmission.

Parameters:
- TIMEOUT_CYCLES, 50000, Clock cycles with no PS/2 falling edge mid-frame before the frame is abandoned (1 ms at 50 MHz).
- SYNC_STAGES, 2, Flip-flop stages synchronising PS2_CLK and PS2_DAT into the Clock domain (minimum 2).

Ports:
- Clock  input  1  System clock, 50 MHz.
- Reset  input  1  Asynchronous, active-high reset.
- PS2_CLK  input  1  Keyboard clock pin; asynchronous to Clock.
- PS2_DAT  input  1  Keyboard data pin; asynchronous to Clock.
- left_held  output  1  High while the left arrow is held.
- right_held  output  1  High while the right arrow is held.
- scan_byte  output  8  Last correctly received byte.
- byte_valid  output  1  One-cycle pulse when scan_byte updates.
- frame_error  output  1  One-cycle pulse on a parity, start or stop error, or on timeout.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs are 0.
  - FSM goes to IDLE.
  - Prefix flags ext_seen and brk_seen are cleared.
  - Synchroniser flops are preset to 1 (idle bus).
  - Reset asserted mid-frame abandons the frame; no byte_valid or frame_error is produced.
- Synchronisation and edge detection:
  - PS2_CLK and PS2_DAT each pass through SYNC_STAGES flops.
  - A falling edge is a synced clock 1 in the previous cycle and 0 in the current cycle.
  - PS2_DAT is sampled in the cycle the falling edge is detected.
- Receive FSM (all transitions occur only on a detected falling edge, except timeout):
  - IDLE: sampled 0 -> DATA with bit count 0. Sampled 1 -> stay in IDLE and pulse frame_error.
  - DATA: shift 8 bits LSB first, then go to PARITY.
  - PARITY: store the parity bit, then go to STOP.
  - STOP: the frame is good only if odd parity holds over the 8 data bits plus the parity bit, and the stop bit is 1.
    - Good frame: go to IDLE and, in the next cycle, pulse byte_valid, load scan_byte and run the decode step.
    - Bad frame: go to IDLE, pulse frame_error, clear ext_seen and brk_seen, leave scan_byte unchanged.
- Timeout:
  - An idle counter resets on every falling edge and counts only while the FSM is not in IDLE.
  - At TIMEOUT_CYCLES: go to IDLE, pulse frame_error, clear both prefix flags.
- Decode step (same cycle as byte_valid):
  - 0xE0: set ext_seen.
  - 0xF0: set brk_seen.
  - Any other byte:
    - If ext_seen and the byte is 0x6B: left_held <= !brk_seen.
    - If ext_seen and the byte is 0x74: right_held <= !brk_seen.
    - Other codes do not change the held outputs.
    - Both flags clear afterwards.
  - Non-extended 0x6B or 0x74 (keypad 4/6 with NumLock) has no effect.
- Held-key rules:
  - Typematic repeats (repeated make codes) keep the level high without glitching.
  - Both arrows may be high simultaneously; this block applies no priority.
  - A break without a preceding make is harmless: the output stays 0.
  - Outputs change only in the decode cycle.
- Latency: byte_valid occurs SYNC_STAGES+2 Clock cycles after the raw PS2_CLK falling edge of the stop bit.

Optional Feature:
- Macro PS2_WASD_EN.
- Defined: non-extended 0x1C (A) drives left_held and 0x23 (D) drives right_held, using the same make/break rules. Each output is the OR of two internal held bits (arrow, letter), so releasing one key while the other stays held keeps the output high.
- Undefined: letter codes are ignored and only the arrow bits exist.

Test Plan:
- Send frames E0, 6B (odd parity correct) -> left_held rises in the byte_valid cycle of 6B; scan_byte = 0x6B; right_held stays 0.
- With left held, send E0, F0, 6B -> left_held falls on the third byte_valid; three byte_valid pulses and no frame_error.
- Send E0 74, then E0 6B, then E0 F0 74 -> both outputs high after the second code; right_held drops after the third code while left_held stays 1.
- Send frame 0x6B with a flipped parity bit after E0 -> frame_error pulses, no byte_valid, left_held stays 0; then a following lone 6B has no effect because ext_seen was cleared.
- With TIMEOUT_CYCLES = 100, stop PS2_CLK after 4 data bits -> frame_error pulses 100 cycles after the last edge, FSM returns to IDLE, and the next complete E0 6B sets left_held.
- Assert Reset mid-frame with left_held = 1 -> all outputs drop to 0 immediately, with no frame_error; with PS2_WASD_EN defined, a following 1C sets left_held and F0 1C clears it.
